mac_pe: RTL and testbench

MAC_PE -- requirements
Module: mac_pe

---
 rtl/mac_pkg.sv | 10 +
 rtl/mac_pe_if.sv | 33 +++
 rtl/mac_sat_add.sv | 21 ++
 rtl/mac_pe.sv | 85 ++++++++
 tb/tb_mac_pe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state encoding and default widths for the MAC processing element.
package mac_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    HOLD  = 2'd1,
    PASS  = 2'd2
  } state_e;
endpackage

// File: rtl/mac_pe_if.sv
// mac_pe_if: operand/flag forwarding, psum drain chain and status bundle of one PE.
interface mac_pe_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] w_in;
  logic              valid_in;
  logic              first_in;
  logic              last_in;
  logic              drain_en;
  logic [ACC_W-1:0]  psum_in;
  logic              psum_valid_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] w_out;
  logic              valid_out;
  logic              first_out;
  logic              last_out;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_valid_out;
  logic              ovf;
  logic [1:0]        state_o;
  modport master (
    output a_in, w_in, valid_in, first_in, last_in, drain_en, psum_in, psum_valid_in,
    input  a_out, w_out, valid_out, first_out, last_out, psum_out, psum_valid_out, ovf, state_o
  );
  modport slave (
    input  a_in, w_in, valid_in, first_in, last_in, drain_en, psum_in, psum_valid_in,
    output a_out, w_out, valid_out, first_out, last_out, psum_out, psum_valid_out, ovf, state_o
  );
endinterface

// File: rtl/mac_sat_add.sv
// mac_sat_add: ACC_W-wide adder with overflow detect and optional clamp to the representable range.
module mac_sat_add #(
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);
  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] clamp;
  assign raw = {1'b0, a_i} + {1'b0, b_i};
  // signed overflow: like-signed operands producing a result of the other sign
  assign ovf_o = (SIGNED != 0) ? (a_i[ACC_W-1] == b_i[ACC_W-1] && raw[ACC_W-1] != a_i[ACC_W-1])
                               : raw[ACC_W];
  assign clamp = (SIGNED == 0) ? '1
               : a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign sum_o = (ovf_o && SATURATE != 0) ? clamp : raw[ACC_W-1:0];
endmodule

// File: rtl/mac_pe.sv
// mac_pe: output-stationary MAC processing element; accumulates a tile, then
// hands its result into the psum drain chain.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input logic     clk,
  input logic     rst,
  mac_pe_if.slave pe
);
  localparam int PW = 2 * DATA_W;
  state_e               state_q, state_d;
  logic [DATA_W-1:0]    a_q, w_q;
  logic                 valid_q, first_q, last_q;
  logic [ACC_W-1:0]     acc_q, acc_d, psum_q, psum_d;
  logic                 ovf_q, ovf_d, psum_valid_q, psum_valid_d;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0]        prod_u;
  logic [ACC_W-1:0]     prod_ext, add_a, sum;
  logic                 add_ovf, accept, draining;
  assign prod_s   = PW'($signed(pe.a_in)) * PW'($signed(pe.w_in));
  assign prod_u   = PW'(pe.a_in) * PW'(pe.w_in);
  assign prod_ext = (SIGNED != 0) ? ACC_W'(prod_s) : ACC_W'(prod_u);
  assign accept   = state_q == ACCUM && pe.valid_in;
  assign draining = pe.drain_en && state_q == HOLD;
  // a tile opener adds onto zero so the product lands unmodified
  assign add_a    = pe.first_in ? '0 : acc_q;
  mac_sat_add #(
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_add (
    .a_i  (add_a),
    .b_i  (prod_ext),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );
  always_comb begin
    acc_d        = accept ? sum : acc_q;
    ovf_d        = accept ? (add_ovf | (ovf_q & ~pe.first_in)) : ovf_q;
    psum_d       = draining ? acc_q : pe.drain_en ? pe.psum_in : psum_q;
    psum_valid_d = pe.drain_en && (draining || pe.psum_valid_in);
    state_d      = (accept && pe.last_in) ? HOLD
                 : draining ? PASS
                 : (!pe.drain_en && state_q == PASS) ? ACCUM : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      w_q          <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      state_q      <= ACCUM;
    end else begin
      a_q          <= pe.a_in;
      w_q          <= pe.w_in;
      valid_q      <= pe.valid_in;
      first_q      <= pe.first_in;
      last_q       <= pe.last_in;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      state_q      <= state_d;
    end
  end
  assign pe.a_out          = a_q;
  assign pe.w_out          = w_q;
  assign pe.valid_out      = valid_q;
  assign pe.first_out      = first_q;
  assign pe.last_out       = last_q;
  assign pe.psum_out       = psum_q;
  assign pe.psum_valid_out = psum_valid_q;
  assign pe.ovf            = ovf_q;
  assign pe.state_o        = state_q;
endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed scoreboard bench for mac_pe covering tiles, saturation/wrap,
// HOLD immunity, the 3-PE drain chain, PASS->ACCUM hand-off and mid-tile reset.
module tb_mac_pe;
  import mac_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  mac_pe_if #(.DATA_W(8), .ACC_W(24)) i_d ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) i_s ();
  mac_pe_if #(.DATA_W(8), .ACC_W(16)) i_w ();
  mac_pe_if #(.DATA_W(8), .ACC_W(24)) i_c0 ();
  mac_pe_if #(.DATA_W(8), .ACC_W(24)) i_c1 ();
  mac_pe_if #(.DATA_W(8), .ACC_W(24)) i_c2 ();
  mac_pe u_d (.clk(clk), .rst(rst), .pe(i_d.slave));
  mac_pe #(.ACC_W(16), .SATURATE(1)) u_s (.clk(clk), .rst(rst), .pe(i_s.slave));
  mac_pe #(.ACC_W(16), .SATURATE(0)) u_w (.clk(clk), .rst(rst), .pe(i_w.slave));
  mac_pe u_c0 (.clk(clk), .rst(rst), .pe(i_c0.slave));
  mac_pe u_c1 (.clk(clk), .rst(rst), .pe(i_c1.slave));
  mac_pe u_c2 (.clk(clk), .rst(rst), .pe(i_c2.slave));
  assign i_c1.psum_in       = i_c0.psum_out;
  assign i_c1.psum_valid_in = i_c0.psum_valid_out;
  assign i_c2.psum_in       = i_c1.psum_out;
  assign i_c2.psum_valid_in = i_c1.psum_valid_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic drv_d(input logic [7:0] a, input logic [7:0] w, input logic v, input logic f, input logic l, input logic dr);
    i_d.a_in = a; i_d.w_in = w; i_d.valid_in = v; i_d.first_in = f; i_d.last_in = l; i_d.drain_en = dr;
  endtask

  task automatic drv_sw(input logic [7:0] a, input logic [7:0] w, input logic v, input logic f, input logic l, input logic dr);
    i_s.a_in = a; i_s.w_in = w; i_s.valid_in = v; i_s.first_in = f; i_s.last_in = l; i_s.drain_en = dr;
    i_w.a_in = a; i_w.w_in = w; i_w.valid_in = v; i_w.first_in = f; i_w.last_in = l; i_w.drain_en = dr;
  endtask

  task automatic drv_c(input logic v, input logic f, input logic l, input logic dr);
    i_c0.a_in = 8'd1; i_c0.w_in = 8'd1; i_c0.valid_in = v; i_c0.first_in = f; i_c0.last_in = l; i_c0.drain_en = dr;
    i_c1.a_in = 8'd1; i_c1.w_in = 8'd2; i_c1.valid_in = v; i_c1.first_in = f; i_c1.last_in = l; i_c1.drain_en = dr;
    i_c2.a_in = 8'd1; i_c2.w_in = 8'd3; i_c2.valid_in = v; i_c2.first_in = f; i_c2.last_in = l; i_c2.drain_en = dr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv_sw(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv_c(1'b0, 1'b0, 1'b0, 1'b0);
    i_d.psum_in = '0; i_d.psum_valid_in = 1'b0;
    i_s.psum_in = '0; i_s.psum_valid_in = 1'b0;
    i_w.psum_in = '0; i_w.psum_valid_in = 1'b0;
    i_c0.psum_in = '0; i_c0.psum_valid_in = 1'b0;
    tick();
    tick();
    chk("rst_state", 64'(i_d.state_o), 64'(ACCUM));
    chk("rst_psum", 64'(i_d.psum_out), 64'd0);
    chk("rst_psum_valid", 64'(i_d.psum_valid_out), 64'd0);
    chk("rst_ovf", 64'(i_d.ovf), 64'd0);
    chk("rst_a_out", 64'(i_d.a_out), 64'd0);
    rst = 1'b0;
    // default tile: 3*4 + (-2)*5 + 7*7 = 51
    drv_d(8'd3, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fwd_a", 64'(i_d.a_out), 64'd3);
    chk("fwd_w", 64'(i_d.w_out), 64'd4);
    chk("fwd_valid", 64'(i_d.valid_out), 64'd1);
    chk("fwd_first", 64'(i_d.first_out), 64'd1);
    drv_d(8'hFE, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_a_neg", 64'(i_d.a_out), 64'hFE);
    chk("fwd_first_low", 64'(i_d.first_out), 64'd0);
    drv_d(8'd7, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(64'd51);
    tick();
    chk("fwd_last", 64'(i_d.last_out), 64'd1);
    chk("tile_hold", 64'(i_d.state_o), 64'(HOLD));
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_sb("tile_psum", 64'(i_d.psum_out));
    chk("tile_psum_valid", 64'(i_d.psum_valid_out), 64'd1);
    chk("tile_ovf", 64'(i_d.ovf), 64'd0);
    chk("tile_pass", 64'(i_d.state_o), 64'(PASS));
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pass_to_accum", 64'(i_d.state_o), 64'(ACCUM));
    chk("drain_off_valid", 64'(i_d.psum_valid_out), 64'd0);
    // single-beat tile (-128)*(-128), then a stray beat while in HOLD
    drv_d(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("single_hold", 64'(i_d.state_o), 64'(HOLD));
    drv_d(8'd5, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(64'd16384);
    tick();
    chk("hold_stays", 64'(i_d.state_o), 64'(HOLD));
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_sb("hold_immune_psum", 64'(i_d.psum_out));
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    // 16-bit saturate vs wrap: four beats of 127*127 = 16129
    drv_sw(8'd127, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drv_sw(8'd127, 8'd127, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_no_ovf_yet", 64'(i_s.ovf), 64'd0);
    tick();
    chk("sat_ovf_set", 64'(i_s.ovf), 64'd1);
    chk("wrap_ovf_set", 64'(i_w.ovf), 64'd1);
    drv_sw(8'd127, 8'd127, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sat_hold", 64'(i_s.state_o), 64'(HOLD));
    drv_sw(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sat_psum", 64'(i_s.psum_out), 64'd32767);
    chk("wrap_psum", 64'(i_w.psum_out), 64'd64516);
    chk("wrap_ovf_sticky", 64'(i_w.ovf), 64'd1);
    drv_sw(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv_sw(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("first_clears_ovf", 64'(i_s.ovf), 64'd0);
    drv_sw(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // three-PE chain holding 1, 2, 3 drains last-to-first
    drv_c(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("chain_hold", 64'(i_c2.state_o), 64'(HOLD));
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd2);
    exp_q.push_back(64'd1);
    drv_c(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("chain_valid_%0d", i), 64'(i_c2.psum_valid_out), 64'd1);
      chk_sb($sformatf("chain_psum_%0d", i), 64'(i_c2.psum_out));
    end
    // a tile opener during PASS->ACCUM is ignored, then taken once in ACCUM
    drv_c(1'b0, 1'b0, 1'b0, 1'b0);
    i_c2.a_in = 8'd9; i_c2.w_in = 8'd9; i_c2.valid_in = 1'b1; i_c2.first_in = 1'b1; i_c2.last_in = 1'b1;
    tick();
    chk("pass_exit_reject", 64'(i_c2.state_o), 64'(ACCUM));
    chk("chain_valid_off", 64'(i_c2.psum_valid_out), 64'd0);
    exp_q.push_back(64'd81);
    tick();
    chk("accum_accept", 64'(i_c2.state_o), 64'(HOLD));
    i_c2.valid_in = 1'b0; i_c2.first_in = 1'b0; i_c2.last_in = 1'b0; i_c2.drain_en = 1'b1;
    tick();
    chk_sb("accept_psum", 64'(i_c2.psum_out));
    i_c2.drain_en = 1'b0;
    // reset on the second beat discards the partial tile
    drv_d(8'd5, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drv_d(8'd6, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_a", 64'(i_d.a_out), 64'd0);
    chk("mrst_w", 64'(i_d.w_out), 64'd0);
    chk("mrst_valid", 64'(i_d.valid_out), 64'd0);
    chk("mrst_first", 64'(i_d.first_out), 64'd0);
    chk("mrst_last", 64'(i_d.last_out), 64'd0);
    chk("mrst_psum", 64'(i_d.psum_out), 64'd0);
    chk("mrst_psum_valid", 64'(i_d.psum_valid_out), 64'd0);
    chk("mrst_ovf", 64'(i_d.ovf), 64'd0);
    chk("mrst_state", 64'(i_d.state_o), 64'(ACCUM));
    rst = 1'b0;
    drv_d(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(64'd4);
    tick();
    chk("post_rst_hold", 64'(i_d.state_o), 64'(HOLD));
    drv_d(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_sb("post_rst_psum", 64'(i_d.psum_out));
    chk("post_rst_valid", 64'(i_d.psum_valid_out), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
